// File: rtl/lane_serializer_pkg.sv
// Shared defaults and types for the lane serializer: default geometry, index/count types
// sized for the default 16x16 configuration, and the two-state burst FSM encoding.
package lane_ser_pkg;

    localparam int LANE_W_DEF    = 16;
    localparam int NUM_LANES_DEF = 16;
    localparam int IDX_W_DEF     = $clog2(NUM_LANES_DEF);
    localparam int CNT_W_DEF     = IDX_W_DEF + 1;

    typedef logic [IDX_W_DEF-1:0] lane_idx_t;
    typedef logic [CNT_W_DEF-1:0] beat_cnt_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_t;

endpackage

// File: rtl/lane_serializer_if.sv
// Load-side and beat-side handshake bundle of the lane serializer.
// master = surrounding datapath/consumer, slave = the serializer itself.
interface lane_ser_if #(
    parameter int LANE_W    = 16,
    parameter int NUM_LANES = 16
);
    localparam int IDX_W = $clog2(NUM_LANES);
    localparam int CNT_W = IDX_W + 1;

    logic                        flush;
    logic                        in_valid;
    logic                        in_ready;
    logic [LANE_W*NUM_LANES-1:0] in_data;
    logic [IDX_W-1:0]            in_start;
    logic [CNT_W-1:0]            in_count;
    logic                        in_msb_first;
    logic                        out_valid;
    logic                        out_ready;
    logic [LANE_W-1:0]           out_data;
    logic [IDX_W-1:0]            out_lane;
    logic                        out_last;
    logic                        busy;

    modport master (
        output flush, in_valid, in_data, in_start, in_count, in_msb_first, out_ready,
        input  in_ready, out_valid, out_data, out_lane, out_last, busy
    );

    modport slave (
        input  flush, in_valid, in_data, in_start, in_count, in_msb_first, out_ready,
        output in_ready, out_valid, out_data, out_lane, out_last, busy
    );

endinterface

// File: rtl/lane_serializer_mux.sv
// Combinational lane select: picks lane i_sel out of a packed NUM_LANES x LANE_W word.
module lane_mux #(
    parameter int LANE_W    = 16,
    parameter int NUM_LANES = 16
) (
    input  logic [LANE_W*NUM_LANES-1:0]   i_data,
    input  logic [$clog2(NUM_LANES)-1:0]  i_sel,
    output logic [LANE_W-1:0]             o_lane
);

    localparam int IDX_W = $clog2(NUM_LANES);

    always_comb begin
        o_lane = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (i_sel == IDX_W'(k)) begin
                o_lane = i_data[k*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/lane_serializer.sv
// Captures a wide result word and streams a programmable run of its lanes out one beat at a time.
// Back-to-back loads are accepted on the last-beat handshake so consecutive bursts have no bubble.
module lane_serializer
    import lane_ser_pkg::*;
#(
    parameter int LANE_W    = LANE_W_DEF,
    parameter int NUM_LANES = NUM_LANES_DEF
) (
    input  logic      clk,
    input  logic      reset,
    lane_ser_if.slave bus
);

    localparam int IDX_W = $clog2(NUM_LANES);
    localparam int CNT_W = IDX_W + 1;

    ser_state_t                  r_state;
    logic [LANE_W*NUM_LANES-1:0] r_buf;
    logic [IDX_W-1:0]            r_idx;
    logic [CNT_W-1:0]            r_rem;
    logic                        r_msb;
    logic                        r_valid;
    logic                        r_last;
    logic [LANE_W-1:0]           r_data;

    logic                        w_fire;
    logic                        w_inReady;
    logic                        w_load;
    logic [CNT_W-1:0]            w_cnt;
    logic [IDX_W-1:0]            w_stepIdx;
    logic [IDX_W-1:0]            w_selIdx;
    logic [LANE_W*NUM_LANES-1:0] w_srcData;
    logic [LANE_W-1:0]           w_laneData;

    assign w_fire    = r_valid & bus.out_ready;
    assign w_inReady = (r_state == IDLE) | (w_fire & r_last);
    assign w_load    = bus.in_valid & w_inReady & ~bus.flush;

    // A zero or oversized count means "the whole word".
    always_comb begin
        w_cnt = bus.in_count;
        if ((bus.in_count == '0) || (bus.in_count > CNT_W'(NUM_LANES))) begin
            w_cnt = CNT_W'(NUM_LANES);
        end
    end

    // Index arithmetic wraps for free because NUM_LANES is a power of two.
    assign w_stepIdx = r_msb ? (r_idx - 1'b1) : (r_idx + 1'b1);
    assign w_selIdx  = w_load ? bus.in_start : w_stepIdx;
    assign w_srcData = w_load ? bus.in_data  : r_buf;

    lane_mux #(
        .LANE_W    (LANE_W),
        .NUM_LANES (NUM_LANES)
    ) u_laneMux (
        .i_data (w_srcData),
        .i_sel  (w_selIdx),
        .o_lane (w_laneData)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_buf   <= '0;
            r_idx   <= '0;
            r_rem   <= '0;
            r_msb   <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (bus.flush) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_state <= SEND;
            r_buf   <= bus.in_data;
            r_idx   <= bus.in_start;
            r_rem   <= w_cnt;
            r_msb   <= bus.in_msb_first;
            r_valid <= 1'b1;
            r_last  <= (w_cnt == CNT_W'(1));
            r_data  <= w_laneData;
        end else if (w_fire) begin
            if (r_last) begin
                r_state <= IDLE;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else begin
                r_idx  <= w_stepIdx;
                r_rem  <= r_rem - 1'b1;
                r_last <= (r_rem == CNT_W'(2));
                r_data <= w_laneData;
            end
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.out_lane  = r_idx;
    assign bus.out_last  = r_last;
    assign bus.busy      = r_valid;

endmodule
